// File: rtl/memseq_pkg.sv
// Shared types and constants for the memory-port sequencer.
package memseq_pkg;

    // Wait-state counter width; covers read latencies 1..7.
    localparam int LAT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Grant pick between the fetch and load/store requesters.
// Optional macro MEMSEQ_RR_EN: round-robin on ties using a last-grant bit
// (reset to data, so the first tie goes to fetch). Without it, data always
// wins over fetch and no state is kept here.
module mem_arbiter
    import memseq_pkg::*;
(
`ifdef MEMSEQ_RR_EN
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   grant_en_i,
`endif
    input  logic   fetch_req_i,
    input  logic   data_req_i,
    output owner_e grant_o,
    output logic   grant_valid_o
);

    assign grant_valid_o = fetch_req_i | data_req_i;

`ifdef MEMSEQ_RR_EN
    owner_e last_q;

    // On a tie, hand the port to whoever did not get it last time.
    always_comb begin
        grant_o = OWN_FETCH;
        if (fetch_req_i && data_req_i) begin
            grant_o = (last_q == OWN_DATA) ? OWN_FETCH : OWN_DATA;
        end else if (data_req_i) begin
            grant_o = OWN_DATA;
        end
    end

    // Remember the most recent grant actually taken by the sequencer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= OWN_DATA;
        end else if (grant_en_i) begin
            last_q <= grant_o;
        end
    end
`else
    // Fixed priority: data over fetch.
    always_comb begin
        grant_o = data_req_i ? OWN_DATA : OWN_FETCH;
    end
`endif

endmodule

// File: rtl/mem_sequencer.sv
// Sequences the shared memory port between instruction fetch and load/store.
// One access at a time: IDLE -> ISSUE -> (WAIT x READ_LAT) -> DONE -> IDLE.
// Optional macro MEMSEQ_RR_EN selects round-robin arbitration in mem_arbiter.
//
// state | meaning
// IDLE  | no access; arbitrate and latch owner/address/data on a request
// ISSUE | drive latched address/data; MemWr high for stores
// WAIT  | read wait states; capture MemDataOut when counter reaches 1
// DONE  | one-cycle Done pulse to the owner; always returns to IDLE
module mem_sequencer
    import memseq_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_done_o,
    output logic [DATA_W-1:0] fetch_data_o,
    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_done_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic [1:0]        state_o
);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  fdata_q, fdata_d;
    logic [DATA_W-1:0]  drdata_q, drdata_d;

    owner_e             grant;
    logic               grant_valid;

`ifdef MEMSEQ_RR_EN
    logic               grant_en;
    assign grant_en = (state_q == IDLE) && grant_valid;
`endif

    mem_arbiter u_arb (
`ifdef MEMSEQ_RR_EN
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .grant_en_i    (grant_en),
`endif
        .fetch_req_i   (fetch_req_i),
        .data_req_i    (data_req_i),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    // Next-state, latching and wait-state counting for the access FSM.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        fdata_d  = fdata_q;
        drdata_d = drdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant;
                    addr_d  = (grant == OWN_DATA) ? data_addr_i : fetch_addr_i;
                    wr_d    = (grant == OWN_DATA) && data_wr_i;
                    wdata_d = data_wdata_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = LAT_W'(READ_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    if (owner_q == OWN_DATA) begin
                        drdata_d = mem_rdata_i;
                    end else begin
                        fdata_d = mem_rdata_i;
                    end
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            owner_q  <= OWN_FETCH;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            fdata_q  <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            fdata_q  <= fdata_d;
            drdata_q <= drdata_d;
        end
    end

    // Outputs decode from registered state only; no request path reaches them.
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_wr_o     = (state_q == ISSUE) && wr_q;
    assign fetch_done_o = (state_q == DONE) && (owner_q == OWN_FETCH);
    assign data_done_o  = (state_q == DONE) && (owner_q == OWN_DATA);
    assign fetch_data_o = fdata_q;
    assign data_rdata_o = drdata_q;
    assign busy_o       = (state_q != IDLE);
    assign state_o      = state_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: three instances (READ_LAT 2, 1, 7) share stimulus.
module tb_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freq = 1'b0, dreq = 1'b0, dwr = 1'b0;
    logic [31:0] faddr = '0, daddr = '0, dwdata = '0, mdout = '0;

    logic        fdone [3];
    logic        ddone [3];
    logic        mwr   [3];
    logic        busy  [3];
    logic [1:0]  st    [3];
    logic [31:0] fdata [3];
    logic [31:0] drdata[3];
    logic [31:0] maddr [3];
    logic [31:0] mdin  [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_sequencer #(
            .ADDR_W(32), .DATA_W(32),
            .READ_LAT((g == 0) ? 2 : (g == 1) ? 1 : 7)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .fetch_req_i (freq),
            .fetch_addr_i(faddr),
            .fetch_done_o(fdone[g]),
            .fetch_data_o(fdata[g]),
            .data_req_i  (dreq),
            .data_wr_i   (dwr),
            .data_addr_i (daddr),
            .data_wdata_i(dwdata),
            .data_done_o (ddone[g]),
            .data_rdata_o(drdata[g]),
            .mem_addr_o  (maddr[g]),
            .mem_wr_o    (mwr[g]),
            .mem_wdata_o (mdin[g]),
            .mem_rdata_i (mdout),
            .busy_o      (busy[g]),
            .state_o     (st[g])
        );
    end

    typedef struct {
        logic        freq;
        logic [31:0] faddr;
        logic        dreq;
        logic        dwr;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] mdout;
        logic [1:0]  e_st;
        logic        e_busy;
        logic        e_mwr;
        logic [31:0] e_maddr;
        logic [31:0] e_mdin;
        logic        e_fdone;
        logic        e_ddone;
        logic [31:0] e_fdata;
        logic [31:0] e_drdata;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic fq, logic [31:0] fa, logic dq, logic w,
                                logic [31:0] da, logic [31:0] dw, logic [31:0] md,
                                logic [1:0] s, logic b, logic mw, logic [31:0] ma,
                                logic [31:0] mi, logic fd, logic dd,
                                logic [31:0] fdt, logic [31:0] drd);
        vec_t v;
        v.freq = fq; v.faddr = fa; v.dreq = dq; v.dwr = w; v.daddr = da;
        v.dwdata = dw; v.mdout = md; v.e_st = s; v.e_busy = b; v.e_mwr = mw;
        v.e_maddr = ma; v.e_mdin = mi; v.e_fdone = fd; v.e_ddone = dd;
        v.e_fdata = fdt; v.e_drdata = drd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        freq = 0; dreq = 0; dwr = 0; faddr = '0; daddr = '0; dwdata = '0; mdout = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] got[4];
        logic [31:0] exp_g[4];
        int          ng;
        int          n_exp;
        int          pat[5];
        int          done_at[3];
        logic        seen_done;

        // Fetch read with READ_LAT=2, request dropped mid-access
        vecs[0]  = mk(1, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF, 2'd1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 32'h99, 0, 0, 0, 0, 32'hDEADBEEF, 2'd2, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 32'h99, 0, 0, 0, 0, 32'hDEADBEEF, 2'd2, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 32'h99, 0, 0, 0, 0, 32'hDEADBEEF, 2'd3, 1, 0, 32'h10, 0, 1, 0, 32'hDEADBEEF, 0);
        vecs[4]  = mk(0, 32'h99, 0, 0, 0, 0, 32'hDEADBEEF, 2'd0, 0, 0, 32'h10, 0, 0, 0, 32'hDEADBEEF, 0);
        // Store; inputs changed after latching are ignored
        vecs[5]  = mk(0, 0, 1, 1, 32'h40, 32'h1234, 32'hDEADBEEF, 2'd1, 1, 1, 32'h40, 32'h1234, 0, 0, 32'hDEADBEEF, 0);
        vecs[6]  = mk(0, 0, 1, 0, 32'h77, 32'hFFFF, 32'hDEADBEEF, 2'd3, 1, 0, 32'h40, 32'h1234, 0, 1, 32'hDEADBEEF, 0);
        vecs[7]  = mk(0, 0, 0, 0, 32'h77, 32'hFFFF, 32'hDEADBEEF, 2'd0, 0, 0, 32'h40, 32'h1234, 0, 0, 32'hDEADBEEF, 0);
        // Load, request held through Done -> re-issued after the idle bubble
        vecs[8]  = mk(0, 0, 1, 0, 32'h80, 32'h5555, 32'hCAFE0001, 2'd1, 1, 0, 32'h80, 32'h5555, 0, 0, 32'hDEADBEEF, 0);
        vecs[9]  = mk(0, 0, 1, 0, 32'h80, 32'h5555, 32'hCAFE0001, 2'd2, 1, 0, 32'h80, 32'h5555, 0, 0, 32'hDEADBEEF, 0);
        vecs[10] = mk(0, 0, 1, 0, 32'h80, 32'h5555, 32'hCAFE0001, 2'd2, 1, 0, 32'h80, 32'h5555, 0, 0, 32'hDEADBEEF, 0);
        vecs[11] = mk(0, 0, 1, 0, 32'h80, 32'h5555, 32'hCAFE0001, 2'd3, 1, 0, 32'h80, 32'h5555, 0, 1, 32'hDEADBEEF, 32'hCAFE0001);
        vecs[12] = mk(0, 0, 1, 0, 32'h80, 32'h5555, 32'hCAFE0001, 2'd0, 0, 0, 32'h80, 32'h5555, 0, 0, 32'hDEADBEEF, 32'hCAFE0001);
        vecs[13] = mk(0, 0, 1, 0, 32'h84, 32'h6666, 32'h11111111, 2'd1, 1, 0, 32'h84, 32'h6666, 0, 0, 32'hDEADBEEF, 32'hCAFE0001);
        vecs[14] = mk(0, 0, 0, 0, 32'h84, 32'h6666, 32'h11111111, 2'd2, 1, 0, 32'h84, 32'h6666, 0, 0, 32'hDEADBEEF, 32'hCAFE0001);
        vecs[15] = mk(0, 0, 0, 0, 32'h84, 32'h6666, 32'h11111111, 2'd2, 1, 0, 32'h84, 32'h6666, 0, 0, 32'hDEADBEEF, 32'hCAFE0001);
        vecs[16] = mk(0, 0, 0, 0, 32'h84, 32'h6666, 32'h0BADF00D, 2'd3, 1, 0, 32'h84, 32'h6666, 0, 1, 32'hDEADBEEF, 32'h0BADF00D);
        vecs[17] = mk(0, 0, 0, 0, 32'h84, 32'h6666, 32'h0BADF00D, 2'd0, 0, 0, 32'h84, 32'h6666, 0, 0, 32'hDEADBEEF, 32'h0BADF00D);

        // Reset state
        #3;
        chk("rst state", 32'(st[0]), 0);
        chk("rst busy", 32'(busy[0]), 0);
        chk("rst mwr", 32'(mwr[0]), 0);
        chk("rst maddr", maddr[0], 0);
        chk("rst mdin", mdin[0], 0);
        chk("rst done", {30'd0, fdone[0], ddone[0]}, 0);
        chk("rst fdata", fdata[0], 0);
        chk("rst drdata", drdata[0], 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven cycle vectors on the READ_LAT=2 instance
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            freq = vecs[i].freq; faddr = vecs[i].faddr; dreq = vecs[i].dreq;
            dwr = vecs[i].dwr; daddr = vecs[i].daddr; dwdata = vecs[i].dwdata;
            mdout = vecs[i].mdout;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d state", i), 32'(st[0]), 32'(vecs[i].e_st));
            chk($sformatf("v%0d busy", i), 32'(busy[0]), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d mwr", i), 32'(mwr[0]), 32'(vecs[i].e_mwr));
            chk($sformatf("v%0d maddr", i), maddr[0], vecs[i].e_maddr);
            chk($sformatf("v%0d mdin", i), mdin[0], vecs[i].e_mdin);
            chk($sformatf("v%0d fdone", i), 32'(fdone[0]), 32'(vecs[i].e_fdone));
            chk($sformatf("v%0d ddone", i), 32'(ddone[0]), 32'(vecs[i].e_ddone));
            chk($sformatf("v%0d fdata", i), fdata[0], vecs[i].e_fdata);
            chk($sformatf("v%0d drdata", i), drdata[0], vecs[i].e_drdata);
        end

        // Both requesters high from reset release: grant order
        do_reset();
`ifdef MEMSEQ_RR_EN
        n_exp = 4;
        exp_g[0] = 32'hA0; exp_g[1] = 32'hB0; exp_g[2] = 32'hA0; exp_g[3] = 32'hB0;
`else
        n_exp = 2;
        exp_g[0] = 32'hB0; exp_g[1] = 32'hA0; exp_g[2] = 0; exp_g[3] = 0;
`endif
        freq = 1; faddr = 32'hA0; dreq = 1; dwr = 0; daddr = 32'hB0;
        ng = 0;
        for (int c = 0; c < 60 && ng < n_exp; c++) begin
            @(posedge clk);
            #1;
            if (st[0] == 2'd1) begin
                got[ng] = maddr[0];
                ng++;
            end
`ifndef MEMSEQ_RR_EN
            if (ddone[0]) dreq = 0;
`endif
        end
        chk("arb grant count", ng, n_exp);
        for (int i = 0; i < n_exp && i < ng; i++)
            chk($sformatf("arb grant %0d addr", i), got[i], exp_g[i]);

        // Reset during the second WAIT cycle of a load
        do_reset();
        dreq = 1; dwr = 0; daddr = 32'h44; mdout = 32'hAAAA5555;
        @(posedge clk); #1;
        dreq = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid pre state", 32'(st[0]), 2);
        rst_n = 1'b0;
        #1;
        chk("rstmid state", 32'(st[0]), 0);
        chk("rstmid mwr", 32'(mwr[0]), 0);
        chk("rstmid busy", 32'(busy[0]), 0);
        seen_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ddone[0]) seen_done = 1'b1;
        end
        chk("rstmid no done", 32'(seen_done), 0);
        chk("rstmid drdata", drdata[0], 0);

        // Continuous fetch: 5-cycle repeating state pattern
        do_reset();
        pat[0] = 0; pat[1] = 1; pat[2] = 2; pat[3] = 2; pat[4] = 3;
        freq = 1; faddr = 32'h50;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stream c%0d state", k), 32'(st[0]), 32'(pat[(k + 1) % 5]));
            chk($sformatf("stream c%0d fdone", k), 32'(fdone[0]), (pat[(k + 1) % 5] == 3) ? 1 : 0);
        end
        freq = 0;

        // Load latency across READ_LAT = 2, 1, 7
        do_reset();
        dreq = 1; dwr = 0; daddr = 32'h60; mdout = 32'h76543210;
        for (int g = 0; g < 3; g++) done_at[g] = -1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (k == 0) dreq = 0;
            for (int g = 0; g < 3; g++)
                if (ddone[g] && done_at[g] < 0) done_at[g] = k;
        end
        chk("lat2 done edge", done_at[0], 3);
        chk("lat1 done edge", done_at[1], 2);
        chk("lat7 done edge", done_at[2], 8);
        chk("lat2 rdata", drdata[0], 32'h76543210);
        chk("lat1 rdata", drdata[1], 32'h76543210);
        chk("lat7 rdata", drdata[2], 32'h76543210);
        chk("lat7 fdata untouched", fdata[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
Sequences the single shared memory port between two requesters: the instruction-fetch side and the load/store data side.
- Arbitrates between them, issues one access at a time, and inserts the fixed read wait states.
- Returns a one-cycle Done pulse with registered read data.
- Replaces the hard-coded wait states in the main control FSM; that FSM then only raises a request and waits for Done.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
READ_LAT, 2, memory read latency in cycles; legal range 1..7

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
FetchReq  in  1  fetch read request, level; held until FetchDone
FetchAddr  in  ADDR_W  fetch address
FetchDone  out  1  one-cycle pulse: fetch complete, FetchData valid
FetchData  out  DATA_W  registered fetch read data
DataReq  in  1  load/store request, level; held until DataDone
DataWr  in  1  1 = store, 0 = load; sampled with DataReq
DataAddr  in  ADDR_W  load/store address
DataWData  in  DATA_W  store data
DataDone  out  1  one-cycle pulse: load/store complete
DataRData  out  DATA_W  registered load data
MemAddr  out  ADDR_W  memory address
MemWr  out  1  memory write enable
MemDataIn  out  DATA_W  memory write data
MemDataOut  in  DATA_W  memory read data
Busy  out  1  state != IDLE
State  out  2  current state, for debug

Behaviour:
Interface:
- One clock, Clock. Reset is asynchronous and active-low.
- Reset asserted (low): state = IDLE.
- All outputs 0 during and after reset: FetchData, DataRData, latched address/data, wait counter, Busy, MemWr, FetchDone, DataDone.

States (2-bit encoding): IDLE=00, ISSUE=01, WAIT=10, DONE=11.

IDLE:
- If any request is high at the rising edge, arbitrate.
- Latch owner, address, write flag and write data (DataWData; write flag only when the owner is data).
- Go to ISSUE. No request: stay in IDLE.

ISSUE (one cycle):
- MemAddr = latched address; MemDataIn = latched write data.
- MemWr = 1 only if the access is a store.
- Store: next state DONE.
- Load or fetch: load counter with READ_LAT, next state WAIT.

WAIT:
- MemAddr stays held. Counter decrements each cycle.
- When counter == 1: capture MemDataOut into the owner's read-data register; next state DONE.
- WAIT therefore lasts exactly READ_LAT cycles.

DONE (one cycle):
- Owner's Done pulses high. Next state IDLE, unconditionally.
- This gives one mandatory idle bubble between accesses.

Latency, with the request sampled at edge t0:
- Store: Done in cycle t0+2.
- Read: Done in cycle t0+2+READ_LAT.

Output rules:
- MemWr, the Done pulses, Busy and State are decoded from state only; no request input reaches them combinationally.
- MemWr is never high outside ISSUE.
- The non-owner's read register holds its value.

Boundary conditions:
- Requester drops its request before Done: the access still completes and Done still pulses.
- Inputs other than the request are ignored after latching.
- Request still high in the IDLE cycle after Done: treated as a new request.
- Reset mid-access: immediate return to IDLE, MemWr low asynchronously, no Done, the partial read is discarded.

Arbitration:
- Default: fixed priority, data over fetch.
- Fetch can be starved only by back-to-back data requests, which the main FSM never generates.

Optional Feature:
MEMSEQ_RR_EN
- Defined: round-robin arbitration.
  - A last-grant bit is updated at each grant; on a tie, the requester not granted last wins.
  - Reset value of last-grant = data, so the first tie goes to fetch.
- Undefined: fixed data-over-fetch priority; no last-grant register exists.

Decomposition:
- Package memseq_pkg:
  - state enum (IDLE/ISSUE/WAIT/DONE, 2-bit)
  - owner enum (OWN_FETCH/OWN_DATA)
  - counter width constant LAT_W = 3
- Sub-module mem_arbiter:
  - combinational grant pick from FetchReq/DataReq
  - under MEMSEQ_RR_EN, also the last-grant register
- Counter and FSM stay in mem_sequencer.

Test Plan:
1. READ_LAT=2; FetchReq=1, FetchAddr=0x10 at t0; memory returns 0xDEADBEEF → MemAddr=0x10 during t0+1..t0+3; FetchDone=1 only in cycle t0+4; FetchData=0xDEADBEEF.
2. DataReq=1, DataWr=1, DataAddr=0x40, DataWData=0x1234 → MemWr=1 only in cycle t0+1 with MemAddr=0x40, MemDataIn=0x1234; DataDone in cycle t0+2; no read register changes.
3. FetchReq and DataReq both held high from reset release:
   - Macro undefined: data granted first, then fetch after one IDLE bubble.
   - MEMSEQ_RR_EN: fetch first, then alternating data/fetch on every tie.
4. Reset driven low during the second WAIT cycle of a load → same cycle: State=00, MemWr=0, Busy=0; no DataDone ever; DataRData=0.
5. FetchReq held high continuously with READ_LAT=2 → FetchDone every 5 cycles; State sequence 00,01,10,10,11 repeating.
6. Sweep READ_LAT=1 and READ_LAT=7, load at t0 → DataDone in cycle t0+3 and t0+9 respectively; correct data captured.
